// File: rtl/i_mem_fill_ctrl_if.sv
// Request/response types and the bus bundle between the I-cache, the fill
// controller and the backing instruction memory.
package i_mem_fill_pkg;

    typedef struct packed {
        logic        fill_requested_address_valid;
        logic [31:0] fill_requested_address;
    } t_cache2i_mem_req;

    typedef struct packed {
        logic         valid;
        logic [127:0] filled_instruction;
        logic [27:0]  address;
    } t_i_mem2cache_rsp;

endpackage

// Handshakes: a memory read transfers on a cycle where mem_rd_req and
// mem_rd_ready are both high; mem_rd_addr is held while req is high and ready
// is low. mem_rd_rsp_valid qualifies mem_rd_rsp_data for one cycle and cannot
// be back-pressured. Cache request and line response are single-cycle pulses.
interface i_mem_fill_ctrl_if;
    import i_mem_fill_pkg::*;

    t_cache2i_mem_req cache2i_mem_req;
    t_i_mem2cache_rsp i_mem2cache_rsp;
    logic             mem_rd_req;
    logic [31:0]      mem_rd_addr;
    logic             mem_rd_ready;
    logic             mem_rd_rsp_valid;
    logic [31:0]      mem_rd_rsp_data;

    modport master (
        input  cache2i_mem_req,
        output i_mem2cache_rsp,
        output mem_rd_req,
        output mem_rd_addr,
        input  mem_rd_ready,
        input  mem_rd_rsp_valid,
        input  mem_rd_rsp_data
    );

    modport slave (
        output cache2i_mem_req,
        input  i_mem2cache_rsp,
        input  mem_rd_req,
        input  mem_rd_addr,
        output mem_rd_ready,
        output mem_rd_rsp_valid,
        output mem_rd_rsp_data
    );

endinterface

// File: rtl/i_mem_fill_ctrl.sv
// Fetches a 16-byte line as four sequential word reads, one outstanding at a
// time, and returns it to the I-cache with sticky timeout/drop status.
module i_mem_fill_ctrl
    import i_mem_fill_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    i_mem_fill_ctrl_if.master  bus,
    output logic               fill_busy,
    output logic               fill_err_timeout,
    output logic               fill_err_drop,
    output logic [1:0]         fill_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        RSP     = 2'd3
    } state_e;

    // Last RD_WAIT cycle index before the word is re-requested.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [1:0]        wcnt_q, wcnt_d;
    logic [7:0]        tcnt_q, tcnt_d;
    logic [27:0]       base_q, base_d;
    logic [3:0][31:0]  line_q, line_d;
    logic [3:0][31:0]  hold_line_q, hold_line_d;
    logic [27:0]       hold_addr_q, hold_addr_d;
    logic              err_to_q, err_to_d;
    logic              err_drop_q, err_drop_d;

    logic              req_v;
    logic [31:0]       req_addr;
    logic              timeout_hit;
    logic              unused_addr_lsb;

    assign req_v           = bus.cache2i_mem_req.fill_requested_address_valid;
    assign req_addr        = bus.cache2i_mem_req.fill_requested_address;
    assign unused_addr_lsb = ^req_addr[3:0];
    assign timeout_hit     = (tcnt_q == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A response in the timeout cycle takes priority over the retry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_v) state_d = RD_REQ;
            end
            RD_REQ: begin
                if (bus.mem_rd_ready) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.mem_rd_rsp_valid) begin
                    state_d = (wcnt_q == 2'd3) ? RSP : RD_REQ;
                end else if (timeout_hit) begin
                    state_d = RD_REQ;
                end
            end
            RSP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wcnt_d      = wcnt_q;
        tcnt_d      = tcnt_q;
        base_d      = base_q;
        line_d      = line_q;
        hold_line_d = hold_line_q;
        hold_addr_d = hold_addr_q;
        err_to_d    = err_to_q;
        err_drop_d  = err_drop_q;
        case (state_q)
            IDLE: begin
                if (req_v) begin
                    base_d = req_addr[31:4];
                    wcnt_d = 2'd0;
                end
            end
            RD_REQ: begin
                if (bus.mem_rd_ready) tcnt_d = 8'd0;
            end
            RD_WAIT: begin
                tcnt_d = tcnt_q + 8'd1;
                if (bus.mem_rd_rsp_valid) begin
                    line_d[wcnt_q] = bus.mem_rd_rsp_data;
                    wcnt_d         = wcnt_q + 2'd1;
                    // The presented line only changes when a complete line lands.
                    if (wcnt_q == 2'd3) begin
                        hold_line_d = line_d;
                        hold_addr_d = base_q;
                    end
                end else if (timeout_hit) begin
                    err_to_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
        if (req_v && (state_q != IDLE)) err_drop_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_q      <= 2'd0;
            tcnt_q      <= 8'd0;
            base_q      <= 28'd0;
            line_q      <= '0;
            hold_line_q <= '0;
            hold_addr_q <= 28'd0;
            err_to_q    <= 1'b0;
            err_drop_q  <= 1'b0;
        end else begin
            wcnt_q      <= wcnt_d;
            tcnt_q      <= tcnt_d;
            base_q      <= base_d;
            line_q      <= line_d;
            hold_line_q <= hold_line_d;
            hold_addr_q <= hold_addr_d;
            err_to_q    <= err_to_d;
            err_drop_q  <= err_drop_d;
        end
    end

    always_comb begin
        bus.mem_rd_req      = (state_q == RD_REQ);
        bus.mem_rd_addr     = {base_q, wcnt_q, 2'b00};
        bus.i_mem2cache_rsp = '{valid:              (state_q == RSP),
                                filled_instruction: hold_line_q,
                                address:            hold_addr_q};
        fill_busy           = (state_q != IDLE);
        fill_err_timeout    = err_to_q;
        fill_err_drop       = err_drop_q;
        fill_state          = state_q;
    end

endmodule

// File: tb/tb_i_mem_fill_ctrl.sv
// Directed and randomized fills against a memory responder driven by a
// per-request plan; expected lines, latencies and flags come from that plan.
module tb_i_mem_fill_ctrl;
    import i_mem_fill_pkg::*;

    localparam int TMO = 4;

    typedef struct {
        int          r;
        int          d;
        bit          resp;
        logic [31:0] addr;
        logic [31:0] data;
    } att_t;

    logic       clk;
    logic       rst;
    logic       fill_busy;
    logic       fill_err_timeout;
    logic       fill_err_drop;
    logic [1:0] fill_state;

    i_mem_fill_ctrl_if bus_if ();

    i_mem_fill_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus_if),
        .fill_busy        (fill_busy),
        .fill_err_timeout (fill_err_timeout),
        .fill_err_drop    (fill_err_drop),
        .fill_state       (fill_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int           total = 0;
    int           bad   = 0;
    att_t         plan_q[$];
    logic [127:0] exp_q[$];
    logic [27:0]  tag_q[$];
    logic [31:0]  exp_words[4];
    int           exp_lat;
    bit           exp_to, exp_to_pend, exp_drop;
    logic [127:0] prev_line;
    bit           stale_req = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: one plan entry per read request.
    att_t        cur;
    bit          in_req = 1'b0;
    bit          pend = 1'b0;
    int          stall, pcnt;
    logic [31:0] pdata;

    initial begin : responder
        bus_if.mem_rd_ready     = 1'b0;
        bus_if.mem_rd_rsp_valid = 1'b0;
        bus_if.mem_rd_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            bus_if.mem_rd_ready     = 1'b0;
            bus_if.mem_rd_rsp_valid = 1'b0;
            bus_if.mem_rd_rsp_data  = $urandom;
            if (rst !== 1'b1) begin
                in_req = 1'b0;
                pend   = 1'b0;
                plan_q.delete();
            end else if (stale_req) begin
                bus_if.mem_rd_rsp_valid = 1'b1;
                stale_req = 1'b0;
            end else if (pend) begin
                if (pcnt == 0) begin
                    bus_if.mem_rd_rsp_valid = 1'b1;
                    bus_if.mem_rd_rsp_data  = pdata;
                    pend = 1'b0;
                end else begin
                    pcnt--;
                end
            end else if (bus_if.mem_rd_req === 1'b1) begin
                if (!in_req) begin
                    chk("rd_req_planned", plan_q.size() > 0, 1);
                    if (plan_q.size() > 0) cur = plan_q.pop_front();
                    else cur = '{r: 0, d: 0, resp: 1'b0, addr: bus_if.mem_rd_addr, data: 32'h0};
                    in_req = 1'b1;
                    stall  = cur.r;
                    chk("rd_addr", bus_if.mem_rd_addr, cur.addr);
                end else begin
                    chk("rd_addr_hold", bus_if.mem_rd_addr, cur.addr);
                end
                if (stall == 0) begin
                    bus_if.mem_rd_ready = 1'b1;
                    in_req = 1'b0;
                    if (cur.resp) begin
                        pend  = 1'b1;
                        pcnt  = cur.d;
                        pdata = cur.data;
                    end
                end else begin
                    stall--;
                    // Junk responses while stalled must not be captured.
                    bus_if.mem_rd_rsp_valid = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    task automatic plan_begin();
        exp_lat     = 1;
        exp_to_pend = 1'b0;
    endtask

    task automatic plan_word(input int w, input logic [31:0] a, input int r, input int d,
                             input bit resp, input logic [31:0] data);
        logic [31:0] base;
        base = {a[31:4], 4'h0};
        plan_q.push_back('{r: r, d: d, resp: resp, addr: base + 32'(4 * w), data: data});
        exp_lat += r + 1 + (resp ? d + 1 : TMO);
        if (resp) exp_words[w] = data;
        else exp_to_pend = 1'b1;
    endtask

    task automatic plan_random(input logic [31:0] a);
        plan_begin();
        for (int w = 0; w < 4; w++) begin
            if ($urandom_range(0, 5) == 0) plan_word(w, a, $urandom_range(0, 2), 0, 1'b0, 32'h0);
            plan_word(w, a, $urandom_range(0, 3), $urandom_range(0, TMO - 1), 1'b1, $urandom);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_err_timeout"}, fill_err_timeout, exp_to);
        chk({tag, "_err_drop"}, fill_err_drop, exp_drop);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus_if.cache2i_mem_req = '{fill_requested_address_valid: 1'b0, fill_requested_address: 32'h0};
            chk("idle_valid", bus_if.i_mem2cache_rsp.valid, 0);
            chk("idle_busy", fill_busy, 0);
            chk("idle_line_hold", bus_if.i_mem2cache_rsp.filled_instruction, prev_line);
            chk_flags("idle");
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, bus_if.i_mem2cache_rsp.valid, 0);
        chk({tag, "_line"}, bus_if.i_mem2cache_rsp.filled_instruction, 0);
        chk({tag, "_addr"}, bus_if.i_mem2cache_rsp.address, 0);
        chk({tag, "_rd_req"}, bus_if.mem_rd_req, 0);
        chk({tag, "_rd_addr"}, bus_if.mem_rd_addr, 0);
        chk({tag, "_busy"}, fill_busy, 0);
        chk({tag, "_err_timeout"}, fill_err_timeout, 0);
        chk({tag, "_err_drop"}, fill_err_drop, 0);
        chk({tag, "_state_idle"}, fill_state, 0);
    endtask

    // Issues a request on the next negedge; drop_at>0 injects a second
    // request in that cycle of the fill (1 = first busy cycle).
    task automatic do_fill(input logic [31:0] a, input int drop_at);
        int got;
        logic [127:0] line;
        got = 0;
        @(negedge clk);
        chk("pre_valid_low", bus_if.i_mem2cache_rsp.valid, 0);
        chk("pre_line_hold", bus_if.i_mem2cache_rsp.filled_instruction, prev_line);
        chk_flags("pre");
        exp_q.push_back({exp_words[3], exp_words[2], exp_words[1], exp_words[0]});
        tag_q.push_back(a[31:4]);
        bus_if.cache2i_mem_req = '{fill_requested_address_valid: 1'b1, fill_requested_address: a};
        for (int c = 1; c <= exp_lat + 20; c++) begin
            @(negedge clk);
            bus_if.cache2i_mem_req = '{fill_requested_address_valid: 1'b0, fill_requested_address: 32'h0};
            if (c == drop_at) begin
                bus_if.cache2i_mem_req = '{fill_requested_address_valid: 1'b1,
                                           fill_requested_address: 32'h0000_2000};
                exp_drop = 1'b1;
            end
            if (bus_if.i_mem2cache_rsp.valid === 1'b1) begin
                got = c;
                break;
            end
            chk("busy_during_fill", fill_busy, 1);
            chk("line_hold", bus_if.i_mem2cache_rsp.filled_instruction, prev_line);
        end
        chk("fill_latency", got, exp_lat);
        line = exp_q.pop_front();
        chk("fill_line", bus_if.i_mem2cache_rsp.filled_instruction, line);
        chk("fill_tag", bus_if.i_mem2cache_rsp.address, tag_q.pop_front());
        prev_line = line;
        exp_to = exp_to | exp_to_pend;
    endtask

    initial begin : main
        logic [31:0] a;
        int lat_mark;
        rst = 1'b0;
        bus_if.cache2i_mem_req = '{fill_requested_address_valid: 1'b0, fill_requested_address: 32'h0};
        exp_to    = 1'b0;
        exp_drop  = 1'b0;
        prev_line = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        idle(2);

        // Basic fill.
        plan_begin();
        plan_word(0, 32'h1238, 0, 0, 1'b1, 32'h11);
        plan_word(1, 32'h1238, 0, 0, 1'b1, 32'h22);
        plan_word(2, 32'h1238, 0, 0, 1'b1, 32'h33);
        plan_word(3, 32'h1238, 0, 0, 1'b1, 32'h44);
        chk("basic_plan_latency", exp_lat, 9);
        do_fill(32'h0000_1238, 0);
        chk("basic_line_literal", bus_if.i_mem2cache_rsp.filled_instruction,
            128'h00000044_00000033_00000022_00000011);
        chk("basic_tag_literal", bus_if.i_mem2cache_rsp.address, 28'h0000123);
        idle(2);

        // Backpressure on word1.
        plan_begin();
        plan_word(0, 32'h1230, 0, 0, 1'b1, 32'hA0);
        plan_word(1, 32'h1230, 3, 0, 1'b1, 32'hA1);
        plan_word(2, 32'h1230, 0, 0, 1'b1, 32'hA2);
        plan_word(3, 32'h1230, 0, 0, 1'b1, 32'hA3);
        chk("bp_plan_latency", exp_lat, 12);
        do_fill(32'h0000_1230, 0);
        idle(2);

        // Response in the timeout cycle wins; no error.
        plan_begin();
        plan_word(0, 32'h4440, 0, TMO - 1, 1'b1, 32'hB0);
        plan_word(1, 32'h4440, 0, TMO - 1, 1'b1, 32'hB1);
        plan_word(2, 32'h4440, 0, 0, 1'b1, 32'hB2);
        plan_word(3, 32'h4440, 0, TMO - 1, 1'b1, 32'hB3);
        do_fill(32'h0000_444C, 0);
        idle(1);

        // Timeout on word2, then a response.
        plan_begin();
        plan_word(0, 32'h1238, 0, 0, 1'b1, 32'hC0);
        plan_word(1, 32'h1238, 0, 0, 1'b1, 32'hC1);
        plan_word(2, 32'h1238, 0, 0, 1'b0, 32'h0);
        plan_word(2, 32'h1238, 0, 0, 1'b1, 32'hC2);
        plan_word(3, 32'h1238, 0, 0, 1'b1, 32'hC3);
        chk("to_plan_latency", exp_lat, 14);
        do_fill(32'h0000_1238, 0);
        idle(2);

        // Request during RD_WAIT of word1 is dropped.
        plan_begin();
        plan_word(0, 32'h5670, 0, 0, 1'b1, 32'hD0);
        plan_word(1, 32'h5670, 0, 0, 1'b1, 32'hD1);
        plan_word(2, 32'h5670, 0, 0, 1'b1, 32'hD2);
        plan_word(3, 32'h5670, 0, 0, 1'b1, 32'hD3);
        do_fill(32'h0000_5674, 4);
        idle(12);
        chk("drop_no_extra_reads", plan_q.size(), 0);

        // Reset in the middle of the word2 wait, then a stale response.
        plan_begin();
        plan_word(0, 32'h3000, 0, 0, 1'b1, 32'hE0);
        plan_word(1, 32'h3000, 0, 0, 1'b1, 32'hE1);
        plan_word(2, 32'h3000, 0, 0, 1'b0, 32'h0);
        plan_word(3, 32'h3000, 0, 0, 1'b1, 32'hE3);
        @(negedge clk);
        bus_if.cache2i_mem_req = '{fill_requested_address_valid: 1'b1, fill_requested_address: 32'h3000};
        @(negedge clk);
        bus_if.cache2i_mem_req = '{fill_requested_address_valid: 1'b0, fill_requested_address: 32'h0};
        repeat (6) @(negedge clk);
        chk("pre_reset_busy", fill_busy, 1);
        rst = 1'b0;
        #1;
        chk_zero("async_reset");
        repeat (2) @(negedge clk);
        chk_zero("held_reset");
        rst       = 1'b1;
        stale_req = 1'b1;
        exp_to    = 1'b0;
        exp_drop  = 1'b0;
        prev_line = '0;
        idle(8);
        chk_zero("after_stale");

        // Back-to-back fills after reset.
        plan_begin();
        plan_word(0, 32'h7700, 0, 1, 1'b1, 32'hF0);
        plan_word(1, 32'h7700, 1, 0, 1'b1, 32'hF1);
        plan_word(2, 32'h7700, 0, 2, 1'b1, 32'hF2);
        plan_word(3, 32'h7700, 2, 0, 1'b1, 32'hF3);
        do_fill(32'h0000_7708, 0);
        plan_random(32'h0000_8810);
        do_fill(32'h0000_8810, 0);
        idle(1);

        // Request dropped in the RSP cycle.
        plan_random(32'h0000_9900);
        lat_mark = exp_lat;
        do_fill(32'h0000_9904, lat_mark);
        idle(6);
        chk("rsp_drop_no_extra_reads", plan_q.size(), 0);

        // Randomized fills.
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            plan_random(a);
            do_fill(a, ($urandom_range(0, 3) == 0) ? $urandom_range(1, exp_lat) : 0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(4);
        chk("final_no_pending_reads", plan_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i_mem_fill_ctrl.md
# i_mem_fill_ctrl

Instruction-memory fill controller directly downstream of the IFU instruction cache. It accepts a one-cycle cache-line fill request (`t_cache2i_mem_req`) and fetches the four 32-bit words of the 16-byte line from the backing instruction memory over a single-outstanding read handshake. It assembles them into a 128-bit line and returns it to the cache as `t_i_mem2cache_rsp` with a one-cycle valid pulse. Timeout-retry and busy-drop detection are reported through sticky status outputs.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in RD_WAIT before the current word is re-requested; legal range 1..255.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low: asserting `rst`=0 immediately forces every register below to its reset value.
- `cache2i_mem_req`  in  `t_cache2i_mem_req`  fields: `fill_requested_address_valid` (1), `fill_requested_address` (32).
- `i_mem2cache_rsp`  out  `t_i_mem2cache_rsp`  fields: `valid` (1), `filled_instruction` (128, word0 in [31:0] … word3 in [127:96]), `address` (28, line tag = addr[31:4]).
- `mem_rd_req`  out  1  read request to backing memory.
- `mem_rd_addr`  out  32  word address, always 4-byte aligned.
- `mem_rd_ready`  in  1  memory accepts the request this cycle.
- `mem_rd_rsp_valid`  in  1  read data valid.
- `mem_rd_rsp_data`  in  32  read data.
- `fill_busy`  out  1  high in any state other than IDLE.
- `fill_err_timeout`  out  1  sticky; set on any timeout retry.
- `fill_err_drop`  out  1  sticky; set when a request arrives while busy.

## Operation
- **States:** IDLE, RD_REQ, RD_WAIT, RSP.
- **IDLE:**
  - When `fill_requested_address_valid`=1, capture `base = {addr[31:4],4'b0}` and tag `addr[31:4]`.
  - Clear word counter `wcnt` (2 bits) and go to RD_REQ.
  - Address bits [3:0] are ignored; words are always fetched 0..3, not critical-word-first.
- **RD_REQ:**
  - Drive `mem_rd_req`=1 and `mem_rd_addr = base + 4*wcnt`.
  - When `mem_rd_ready`=1, go to RD_WAIT and clear the timeout counter.
  - `mem_rd_rsp_valid` in this state is ignored.
- **RD_WAIT:**
  - `mem_rd_req`=0. The 8-bit timeout counter increments each cycle.
  - When `mem_rd_rsp_valid`=1, write data into line slot `wcnt`.
    - If `wcnt`=3, go to RSP.
    - Otherwise `wcnt`+1 and go to RD_REQ.
  - If the counter reaches `TIMEOUT_CYCLES` with no response, set `fill_err_timeout` and return to RD_REQ with the same `wcnt`.
  - A response arriving in the same cycle as the timeout wins: data is taken and no error is set.
- **RSP:**
  - `i_mem2cache_rsp.valid`=1 for exactly one cycle, then go to IDLE.
  - `filled_instruction` and `address` are driven from holding registers and stay stable until the next fill reaches RSP. The cache latches the line in the cycle after the valid pulse, so the data must still be present then.
- **Request while not IDLE** (including the RSP cycle):
  - The request is dropped and `fill_err_drop` is set.
  - The in-progress fill is unaffected.
- **Sticky flags** clear only on reset.
- **Reset values:**
  - All outputs 0: `valid`, `filled_instruction`, `address`, `mem_rd_req`, `mem_rd_addr`, `fill_busy`, both error flags.
  - State=IDLE, `wcnt`=0, timeout counter=0.
  - A reset mid-fill abandons the fill: no response is issued, and a late `mem_rd_rsp_valid` after reset release is ignored in IDLE.

## Timing
- Request sampled in IDLE at edge T → `mem_rd_req`=1 in cycle T+1.
- With `mem_rd_ready` held 1 and response one cycle after acceptance, each word costs 2 cycles. Word3 data arrives in cycle T+8 and `valid` pulses in cycle T+9: 9-cycle best-case fill latency.
- Each cycle of `mem_rd_ready`=0 or response delay adds one cycle.
- `mem_rd_addr` is held stable while `mem_rd_req`=1 and `mem_rd_ready`=0.
- At most one memory read is outstanding.
- The earliest next request is accepted the cycle after RSP.

## Test plan
- **Basic fill:** request addr 0x0000_1238, memory returns 0x11,0x22,0x33,0x44 for addrs 0x1230/34/38/3C → `valid` one cycle at T+9, `filled_instruction`=0x00000044_00000033_00000022_00000011, `address`=0x0000123.
- **Backpressure:** `mem_rd_ready`=0 for 3 cycles on word1 → `mem_rd_addr` holds 0x1234 throughout, `valid` at T+12, data correct.
- **Timeout:** `TIMEOUT_CYCLES`=4, no response to word2 → re-request of 0x1238 after 4 wait cycles, `fill_err_timeout`=1; line completes once a response is given.
- **Busy drop:** second request (0x2000) during RD_WAIT of the first fill → `fill_err_drop`=1, first fill completes with its own tag, no second fill.
- **Reset mid-fill:** drop `rst` to 0 during word2 wait, then release and give a stale response → no `valid`, all outputs 0, state IDLE; a new request fills normally.
- **Back-to-back fills:** second request issued the cycle after RSP → accepted, both lines correct, `filled_instruction` holds line1 until line2's RSP.
